// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   // Arbiter FSM states: idle, fetch access in flight, data access in flight.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arbState_t;

   // Addresses are byte addresses of 32-bit words; the word index starts here.
   localparam int WORD_LSB = 2;

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry instruction buffer: remembers the last fetched word so a repeated
// fetch of the same word can be answered without touching memory.
module mem_arb_ibuf
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [AW-WORD_LSB-1:0] lookupTag,
   input  logic                   fillEn,
   input  logic [AW-WORD_LSB-1:0] fillTag,
   input  logic [DW-1:0]          fillData,
   input  logic                   invEn,
   input  logic [AW-WORD_LSB-1:0] invTag,
   output logic                   hit,
   output logic [DW-1:0]          hitData
);

   logic [AW-WORD_LSB-1:0] tagQ;
   logic [DW-1:0]          dataQ;
   logic                   validQ;

   // Every completed fetch refills the entry; a store to the buffered word kills it.
   always_ff @(posedge clk) begin
      if (reset) begin
         validQ <= 1'b0;
         tagQ   <= '0;
         dataQ  <= '0;
      end else if (fillEn) begin
         validQ <= 1'b1;
         tagQ   <= fillTag;
         dataQ  <= fillData;
      end else if (invEn && (invTag == tagQ)) begin
         validQ <= 1'b0;
      end
   end

   assign hit     = validQ && (lookupTag == tagQ);
   assign hitData = dataQ;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and data access, data first. Optional one-entry fetch buffer is compiled in
// when MEMARB_IBUF_EN is defined.
//
// Handshake: a requester raises Req and holds it (with stable address/data)
// until it sees its one-cycle Valid pulse. A request whose Valid is high in the
// current cycle is ignored, so a held Req never issues twice. Toward memory,
// MemReq and the address/write bus stay stable until a one-cycle MemReady.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            IfReq,
   input  logic [AW-1:0]   IfAddr,
   output logic [DW-1:0]   IfRData,
   output logic            IfValid,
   input  logic            DmReq,
   input  logic            DmWe,
   input  logic [AW-1:0]   DmAddr,
   input  logic [DW-1:0]   DmWData,
   output logic [DW-1:0]   DmRData,
   output logic            DmValid,
   output logic            MemReq,
   output logic            MemWe,
   output logic [AW-1:0]   MemAddr,
   output logic [DW-1:0]   MemWData,
   input  logic [DW-1:0]   MemRData,
   input  logic            MemReady,
   output logic            StallIF,
   output logic            StallMem,
   output arbState_t       DbgState
);

   arbState_t      state, nextState;
   logic           latWe;
   logic [AW-1:0]  latAddr;
   logic [DW-1:0]  latWData;
   logic           dmGo, ifGo;
   logic           takeD, takeI, takeHit, doneI, doneD;
   logic           ibufHit;
   logic [DW-1:0]  ibufData;

   // A requester already being answered this cycle must not be re-accepted.
   assign dmGo = DmReq & ~DmValid;
   assign ifGo = IfReq & ~IfValid;

   // Next state and one-cycle control strobes; data has priority over fetch.
   always_comb begin
      nextState = state;
      takeD     = 1'b0;
      takeI     = 1'b0;
      takeHit   = 1'b0;
      doneI     = 1'b0;
      doneD     = 1'b0;
      case (state)
         IDLE: begin
            if (dmGo) begin
               takeD     = 1'b1;
               nextState = BUSY_D;
            end else if (ifGo && ibufHit && !DmReq) begin
               takeHit   = 1'b1;
            end else if (ifGo) begin
               takeI     = 1'b1;
               nextState = BUSY_I;
            end
         end
         BUSY_I: begin
            if (MemReady) begin
               doneI     = 1'b1;
               nextState = IDLE;
            end
         end
         BUSY_D: begin
            if (MemReady) begin
               doneD     = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Latch the winning request so the memory bus stays stable until MemReady.
   always_ff @(posedge clk) begin
      if (reset) begin
         latWe    <= 1'b0;
         latAddr  <= '0;
         latWData <= '0;
      end else if (takeD) begin
         latWe    <= DmWe;
         latAddr  <= DmAddr;
         latWData <= DmWData;
      end else if (takeI) begin
         latWe    <= 1'b0;
         latAddr  <= IfAddr;
      end
   end

   // Register responses; read data holds its last value between accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         IfValid <= 1'b0;
         DmValid <= 1'b0;
         IfRData <= '0;
         DmRData <= '0;
      end else begin
         IfValid <= doneI | takeHit;
         DmValid <= doneD;
         if (doneI)        IfRData <= MemRData;
         else if (takeHit) IfRData <= ibufData;
         if (doneD && !latWe) DmRData <= MemRData;
      end
   end

`ifdef MEMARB_IBUF_EN
   mem_arb_ibuf #(
      .AW (AW),
      .DW (DW)
   ) uIbuf (
      .clk       (clk),
      .reset     (reset),
      .lookupTag (IfAddr[AW-1:WORD_LSB]),
      .fillEn    (doneI),
      .fillTag   (latAddr[AW-1:WORD_LSB]),
      .fillData  (MemRData),
      .invEn     (doneD & latWe),
      .invTag    (latAddr[AW-1:WORD_LSB]),
      .hit       (ibufHit),
      .hitData   (ibufData)
   );
`else
   assign ibufHit  = 1'b0;
   assign ibufData = '0;
`endif

   assign MemReq   = (state != IDLE);
   assign MemWe    = (state == BUSY_D) & latWe;
   assign MemAddr  = latAddr;
   assign MemWData = latWData;
   assign StallIF  = IfReq & ~IfValid;
   assign StallMem = DmReq & ~DmValid;
   assign DbgState = state;

endmodule
